// File: rtl/iot_crc_feeder_if.sv
// iot_crc_feeder_if -- byte-input, CRC-stage and result signals of iot_crc_feeder (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

interface iot_crc_feeder_if;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         busy;
  logic         crc_en;
  logic [127:0] crc_data;
  logic         crc_valid;
  logic [2:0]   crc_result;
  logic         o_valid;
  logic [127:0] o_frame;
  logic [2:0]   o_crc;
  logic         o_err;
  logic [7:0]   o_frame_idx;

  modport master (
    output in_en, iot_in, crc_valid, crc_result,
    input  busy, crc_en, crc_data, o_valid, o_frame, o_crc, o_err, o_frame_idx
  );

  modport slave (
    input  in_en, iot_in, crc_valid, crc_result,
    output busy, crc_en, crc_data, o_valid, o_frame, o_crc, o_err, o_frame_idx
  );
endinterface

`default_nettype wire

// File: rtl/iot_crc_feeder.sv
// iot_crc_feeder -- packs 16 bytes into a 128-bit frame, hands it to a CRC stage and
// reports frame, remainder and timeout status (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

module iot_crc_feeder #(
  parameter int TIMEOUT = 255
) (
  input wire clk,
  input wire rst,
  iot_crc_feeder_if.slave bus
);

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam logic [9:0] C_TMO_LAST = 10'(TIMEOUT - 1);

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic [3:0]   r_byte_cnt;
  logic [9:0]   r_tmo;
  logic [127:0] r_buf;
  logic [127:0] r_crc_data;
  logic         r_crc_en;
  logic         r_valid;
  logic [127:0] r_frame;
  logic [2:0]   r_crc;
  logic         r_err;
  logic [7:0]   r_idx;

  logic         w_accept;
  logic         w_last;
  logic         w_tmo_hit;
  logic         w_busy;
  logic         w_enter_out;
  logic         w_tmo_exit;
  logic [2:0]   w_crc_d;
  logic [127:0] w_buf_shift;

  assign w_accept    = (r_state == S_COLLECT) && bus.in_en;
  assign w_last      = w_accept && (r_byte_cnt == 4'd15);
  assign w_tmo_hit   = (r_tmo == C_TMO_LAST);
  assign w_buf_shift = {r_buf[119:0], bus.iot_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (w_last) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (bus.crc_valid) begin
          w_next = S_CAPTURE;
        end else if (w_tmo_hit) begin
          w_next = S_OUT;
        end
      end
      S_CAPTURE: w_next = S_OUT;
      S_OUT:     w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  // A late crc_valid on the expiry cycle still wins over the timeout.
  always_comb begin
    w_busy      = 1'b0;
    w_enter_out = 1'b0;
    w_tmo_exit  = 1'b0;
    w_crc_d     = 3'b000;
    case (r_state)
      S_ISSUE, S_OUT: w_busy = 1'b1;
      S_WAIT: begin
        w_busy      = 1'b1;
        w_tmo_exit  = !bus.crc_valid && w_tmo_hit;
        w_enter_out = w_tmo_exit;
      end
      S_CAPTURE: begin
        w_busy      = 1'b1;
        w_enter_out = 1'b1;
        w_crc_d     = bus.crc_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 4'd0;
      r_tmo      <= 10'd0;
      r_buf      <= 128'd0;
      r_crc_data <= 128'd0;
      r_crc_en   <= 1'b0;
      r_valid    <= 1'b0;
      r_frame    <= 128'd0;
      r_crc      <= 3'b000;
      r_err      <= 1'b0;
      r_idx      <= 8'd0;
    end else begin
      // The 4-bit counter wraps to 0 on the 16th byte, which starts the next frame.
      if (w_accept) begin
        r_buf      <= w_buf_shift;
        r_byte_cnt <= r_byte_cnt + 4'd1;
      end
      if (w_last) begin
        r_crc_data <= w_buf_shift;
      end
      r_crc_en <= w_last;
      r_tmo    <= (r_state == S_WAIT) ? r_tmo + 10'd1 : 10'd0;
      r_valid  <= w_enter_out;
      r_crc    <= w_crc_d;
      r_err    <= w_tmo_exit;
      if (w_enter_out) begin
        r_frame <= r_buf;
      end
      if (r_state == S_OUT) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.crc_en      = r_crc_en;
  assign bus.crc_data    = r_crc_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame     = r_frame;
  assign bus.o_crc       = r_crc;
  assign bus.o_err       = r_err;
  assign bus.o_frame_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_iot_crc_feeder.sv
// tb_iot_crc_feeder -- directed self-checking bench for iot_crc_feeder (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

module tb_iot_crc_feeder;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  int         rsp_mode = 0;
  int         rsp_lat  = 131;
  logic [2:0] rsp_fixed = 3'b101;

  iot_crc_feeder_if ifc();

  iot_crc_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ifc.o_valid === 1'b1) vcount++;

  function automatic logic [2:0] crc3(input logic [127:0] d);
    logic [2:0] c = 3'b000;
    logic       fb;
    for (int i = 127; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC stage: registers crc_en on the next edge and answers rsp_lat cycles later;
  // mode 0 = fixed result, 1 = real CRC (poly 4'b1011), 2 = never answers.
  initial begin
    logic [2:0] res;
    ifc.crc_valid  = 1'b0;
    ifc.crc_result = 3'b000;
    forever begin
      @(negedge clk);
      if (ifc.crc_en === 1'b1 && rsp_mode != 2) begin
        res = (rsp_mode == 1) ? crc3(ifc.crc_data) : rsp_fixed;
        repeat (rsp_lat + 1) @(negedge clk);
        ifc.crc_valid  = 1'b1;
        ifc.crc_result = ~res;
        @(negedge clk);
        ifc.crc_valid  = 1'b0;
        ifc.crc_result = res;
      end
    end
  end

  task automatic send_frame(input logic [127:0] f, input bit gap);
    for (int i = 0; i < 16; i++) begin
      ifc.iot_in = f[127-8*i -: 8];
      ifc.in_en  = 1'b1;
      @(posedge clk); #1;
      if (gap && i < 15) begin
        ifc.in_en  = 1'b0;
        ifc.iot_in = 8'hA5;
        @(posedge clk); #1;
      end
    end
    ifc.in_en = 1'b0;
    chk("crc_en", ifc.crc_en, 1'b1);
    chk("crc_data", ifc.crc_data, f);
    chk("busy_issue", ifc.busy, 1'b1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (ifc.o_valid !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("o_valid_seen", ifc.o_valid, 1'b1);
  endtask

  task automatic check_out(input logic [127:0] f, input logic [2:0] crc,
                           input logic err, input logic [7:0] idx);
    chk("o_frame", ifc.o_frame, f);
    chk("o_crc", ifc.o_crc, crc);
    chk("o_err", ifc.o_err, err);
    chk("o_frame_idx", ifc.o_frame_idx, idx);
    @(posedge clk); #1;
    chk("o_valid_pulse", ifc.o_valid, 1'b0);
    chk("o_crc_idle", ifc.o_crc, 3'b000);
    chk("o_err_idle", ifc.o_err, 1'b0);
    chk("o_frame_hold", ifc.o_frame, f);
    chk("busy_collect", ifc.busy, 1'b0);
  endtask

  initial begin
    int         lat;
    int         snap;
    logic [7:0] nb;
    rst        = 1'b1;
    ifc.in_en  = 1'b0;
    ifc.iot_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_crc_en", ifc.crc_en, 1'b0);
    chk("rst_o_valid", ifc.o_valid, 1'b0);
    chk("rst_o_frame", ifc.o_frame, 128'd0);
    chk("rst_o_crc", ifc.o_crc, 3'b000);
    chk("rst_o_err", ifc.o_err, 1'b0);
    chk("rst_idx", ifc.o_frame_idx, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Counting bytes, fixed CRC answer, nominal latency.
    rsp_mode = 0; rsp_fixed = 3'b101; rsp_lat = 131;
    send_frame(128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    wait_out(lat);
    chk("latency", lat, 134);
    check_out(128'h000102030405060708090A0B0C0D0E0F, 3'b101, 1'b0, 8'd0);

    // Real CRC stage: all zeros (with idle gaps between bytes), then all ones.
    rsp_mode = 1;
    send_frame(128'd0, 1'b1);
    wait_out(lat);
    check_out(128'd0, 3'b000, 1'b0, 8'd1);
    send_frame({128{1'b1}}, 1'b0);
    wait_out(lat);
    check_out({128{1'b1}}, 3'b101, 1'b0, 8'd2);

    // CRC stage silent: timeout path, then a normal frame.
    rsp_mode = 2;
    send_frame(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 1'b0);
    wait_out(lat);
    chk("tmo_latency", lat, TIMEOUT + 1);
    check_out(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 3'b000, 1'b1, 8'd3);
    rsp_mode = 0; rsp_fixed = 3'b110;
    send_frame(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    wait_out(lat);
    check_out(128'h0123456789ABCDEF_FEDCBA9876543210, 3'b110, 1'b0, 8'd4);

    // in_en held for 40 cycles: bytes beyond the 16th are dropped while busy.
    rsp_fixed = 3'b010;
    for (int i = 0; i < 40; i++) begin
      ifc.iot_in = 8'h40 + 8'(i);
      ifc.in_en  = 1'b1;
      @(posedge clk); #1;
    end
    ifc.in_en = 1'b0;
    chk("held_crc_data", ifc.crc_data, 128'h404142434445464748494A4B4C4D4E4F);
    wait_out(lat);
    check_out(128'h404142434445464748494A4B4C4D4E4F, 3'b010, 1'b0, 8'd5);
    send_frame(128'h8899AABBCCDDEEFF_0011223344556677, 1'b0);
    wait_out(lat);
    check_out(128'h8899AABBCCDDEEFF_0011223344556677, 3'b010, 1'b0, 8'd6);

    // Reset 50 cycles into WAIT.
    rsp_mode = 2;
    send_frame(128'hF0E1D2C3B4A59687_78695A4B3C2D1E0F, 1'b0);
    repeat (51) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("wrst_busy", ifc.busy, 1'b0);
    chk("wrst_crc_en", ifc.crc_en, 1'b0);
    chk("wrst_o_valid", ifc.o_valid, 1'b0);
    chk("wrst_o_frame", ifc.o_frame, 128'd0);
    chk("wrst_o_crc", ifc.o_crc, 3'b000);
    chk("wrst_o_err", ifc.o_err, 1'b0);
    chk("wrst_idx", ifc.o_frame_idx, 8'd0);
    snap = vcount;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("wrst_no_valid", vcount, snap);

    // 257 back-to-back frames with a short CRC response; index wraps to 0.
    rsp_mode = 0; rsp_fixed = 3'b011; rsp_lat = 2;
    snap = vcount;
    for (int n = 0; n < 257; n++) begin
      nb = 8'(n);
      send_frame({16{nb}}, 1'b0);
      wait_out(lat);
      chk("seq_idx", ifc.o_frame_idx, nb);
      chk("seq_frame", ifc.o_frame, {16{nb}});
      @(posedge clk); #1;
      chk("seq_pulse", ifc.o_valid, 1'b0);
    end
    chk("seq_count", vcount - snap, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
